msf_load_ctrl: RTL
==================

# msf_load_ctrl

Sequencing controller for the HH:MM:SS digit counter chain. It counts seconds within an MSF frame and captures the hour and minute time-code bits, then checks parity and BCD ranges. At each second boundary it issues exactly one command to the digit chain. The command is a parallel load of the decoded time (seconds forced to 00) at a valid minute marker, and a plain increment at every other boundary. It sits between the MSF bit decoder and the digit chain: its `inc_o`/`load_o`/value outputs drive the chain's `inc_i`/`load_i`/load-value inputs directly.

## Interface

Parameters:
- `FREEWHEEL_MINUTES`, default 10: number of consecutive invalid frames after which `synced_o` drops.

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  asynchronous, active-high reset
- `sec_tick_i`  in  1  one-cycle pulse at the leading edge of every received second
- `minute_marker_i`  in  1  qualifies `sec_tick_i`: this second is second 00 (ignored without `sec_tick_i`)
- `bit_strobe_i`  in  1  one-cycle pulse: A/B bits of the current second are decoded
- `bit_a_i`  in  1  A bit, valid with `bit_strobe_i`
- `bit_b_i`  in  1  B bit, valid with `bit_strobe_i`
- `bit_err_i`  in  1  decoder could not classify this second, valid with `bit_strobe_i`
- `inc_o`  out  1  one-cycle increment command to the seconds-LSD digit
- `load_o`  out  1  one-cycle parallel-load command to all digits
- `hour_h_o`  out  2  load value, hour tens
- `hour_l_o`  out  4  load value, hour units
- `minute_h_o`  out  3  load value, minute tens
- `minute_l_o`  out  4  load value, minute units
- `second_h_o`  out  3  load value, seconds tens; constant 0
- `second_l_o`  out  4  load value, seconds units; constant 0
- `synced_o`  out  1  set while the clock is locked to MSF
- `frame_err_o`  out  1  one-cycle pulse when a marker closes an invalid frame

## Operation

Second index and frame state:
- `sec_idx` is a 6-bit counter.
  - Set to 0 on a marker tick.
  - Incremented on each non-marker tick.
  - Saturates at 63.
- `frame_bad` flag: cleared on a marker tick. It is set by any of:
  - a strobe with `bit_err_i`=1
  - a second strobe in the same second (a per-second `got_bit` flag is cleared on every tick)
  - `sec_idx`=63 saturation
- A strobe while `sec_idx`>59 is ignored apart from the error checks above.
- Strobes before the first marker after reset are captured but cannot validate, because `frame_bad` is set from reset.

Capture:
- On a strobe with `sec_idx` in 39..51, `bit_a_i` shifts MSB-first into a 13-bit register: hour[5:0], then minute[6:0].
- The strobe at `sec_idx`=54 stores `bit_b_i` as the parity bit `p54`.
- A 14-bit `seen` mask records idx 39..51 and 54.

Validation, evaluated on a marker tick. The frame is valid iff all of:
- `sec_idx`==59 (exactly 60 seconds since the previous marker; leap/short minutes are invalid)
- `frame_bad`==0
- `seen` is all ones
- XOR of the 13 captured bits and `p54` == 1 (odd parity)
- hour tens ≤2
- hour units ≤9
- hour ≤23
- minute tens ≤5
- minute units ≤9

Command per tick (never both outputs in one cycle):
- Marker tick with a valid frame:
  - `load_o`=1.
  - Value outputs take the decoded BCD.
  - `synced_o`←1.
  - The invalid-frame counter clears.
- Marker tick with an invalid frame:
  - `inc_o`=1.
  - `frame_err_o`=1.
  - The invalid-frame counter increments, saturating.
  - When it reaches `FREEWHEEL_MINUTES`, `synced_o`←0.
- Non-marker tick: `inc_o`=1.
- Value outputs hold their last loaded value between loads.

Reset, while asserted, and the values every output holds on release:
- All outputs 0.
- `sec_idx`=0.
- `frame_bad`=1.
- Capture register, `seen`, `p54` and counters cleared.
- Reset mid-frame discards the partial frame.

## Timing

- `inc_o`, `load_o` and `frame_err_o` are registered, asserted in the cycle after `sec_tick_i`, and high for one cycle.
- Value outputs are updated in the same edge that raises `load_o` and are stable while `load_o`=1.
- `synced_o` changes in the same cycle as `load_o`/`frame_err_o`.
- A strobe coincident with a tick belongs to the new second: the tick updates `sec_idx` first, then the strobe uses the new index. A marker tick plus strobe in the same cycle is captured at idx 0.
- Validation uses state as of the cycle the marker tick arrives, before that cycle's coincident strobe.
- Back-to-back ticks on consecutive cycles each produce their own one-cycle command.

## Test plan

- Reset mid-stream, then a full 60-tick frame encoding 13:47 → exactly one `load_o` at the second marker: hour_h=1, hour_l=3, minute_h=4, minute_l=7, seconds 0, `synced_o`=1.
  - Frame bits: idx39..44=010011, idx45..51=1000111, `p54`=0.
  - Sequence: marker, 59 ticks with strobes, marker.
  - The first marker yields `inc_o` + `frame_err_o`.
- Same frame with `p54`=1 → `inc_o` and `frame_err_o` at marker; outputs unchanged; `synced_o` unchanged.
- Valid parity but hour=25 (idx39..44=100101, `p54` odd-corrected) → `frame_err_o`, no load.
- 61-tick frame (leap second) and 59-tick frame → `frame_err_o` each, no load. The following 60-tick valid frame loads.
- After sync, `FREEWHEEL_MINUTES`=2 invalid frames (`bit_err_i` at idx 20) → `synced_o` falls at the 2nd marker. Throughout, every tick yields exactly one of `inc_o`/`load_o`.
- Duplicate strobe at idx 45, and strobe coincident with a marker tick → frame invalid for the former; the latter is captured as idx 0 without affecting the closing validation.

Source files
------------

// File: rtl/msf_load_ctrl.sv
// MSF minute-frame sequencer: counts received seconds, captures the hour/minute
// time-code bits and issues one inc or load command to the HH:MM:SS chain per tick.
module msf_load_ctrl #(
  parameter int unsigned FREEWHEEL_MINUTES = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sec_tick_i,
  input  logic       minute_marker_i,
  input  logic       bit_strobe_i,
  input  logic       bit_a_i,
  input  logic       bit_b_i,
  input  logic       bit_err_i,
  output logic       inc_o,
  output logic       load_o,
  output logic [1:0] hour_h_o,
  output logic [3:0] hour_l_o,
  output logic [2:0] minute_h_o,
  output logic [3:0] minute_l_o,
  output logic [2:0] second_h_o,
  output logic [3:0] second_l_o,
  output logic       synced_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = (FREEWHEEL_MINUTES < 1) ? 1 : $clog2(FREEWHEEL_MINUTES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FREEWHEEL_MINUTES);

  logic [5:0]    sec_idx_q, sec_idx_d;
  logic          frame_bad_q, frame_bad_d;
  logic          got_bit_q, got_bit_d;
  logic [12:0]   cap_q, cap_d;
  logic          p54_q, p54_d;
  logic [13:0]   seen_q, seen_d;
  logic [CW-1:0] bad_cnt_q, bad_cnt_d;
  logic          inc_q, inc_d;
  logic          load_q, load_d;
  logic          frame_err_q, frame_err_d;
  logic          synced_q, synced_d;
  logic [1:0]    hour_h_q, hour_h_d;
  logic [3:0]    hour_l_q, hour_l_d;
  logic [2:0]    minute_h_q, minute_h_d;
  logic [3:0]    minute_l_q, minute_l_d;

  logic [5:0] hour;
  logic [6:0] minute;
  logic       frame_ok;
  logic [3:0] seen_pos;

  assign hour   = cap_q[12:7];
  assign minute = cap_q[6:0];

  // Judged on the frame as it stood before this cycle's tick or strobe.
  assign frame_ok = (sec_idx_q == 6'd59) && !frame_bad_q && (&seen_q)
                 && (^{cap_q, p54_q})
                 && (hour[5:4] <= 2'd2) && (hour[3:0] <= 4'd9)
                 && ((hour[5:4] != 2'd2) || (hour[3:0] <= 4'd3))
                 && (minute[6:4] <= 3'd5) && (minute[3:0] <= 4'd9);

  // NOTE: every variable gets a default first so this block cannot infer a latch.
  always_comb begin
    sec_idx_d   = sec_idx_q;
    frame_bad_d = frame_bad_q;
    got_bit_d   = got_bit_q;
    cap_d       = cap_q;
    p54_d       = p54_q;
    seen_d      = seen_q;
    bad_cnt_d   = bad_cnt_q;
    synced_d    = synced_q;
    hour_h_d    = hour_h_q;
    hour_l_d    = hour_l_q;
    minute_h_d  = minute_h_q;
    minute_l_d  = minute_l_q;
    inc_d       = 1'b0;
    load_d      = 1'b0;
    frame_err_d = 1'b0;
    seen_pos    = 4'(sec_idx_q - 6'd39);

    if (sec_tick_i) begin
      got_bit_d = 1'b0;
      if (minute_marker_i) begin
        sec_idx_d   = 6'd0;
        frame_bad_d = 1'b0;
        seen_d      = '0;
        p54_d       = 1'b0;
        if (frame_ok) begin
          load_d     = 1'b1;
          synced_d   = 1'b1;
          bad_cnt_d  = '0;
          hour_h_d   = hour[5:4];
          hour_l_d   = hour[3:0];
          minute_h_d = minute[6:4];
          minute_l_d = minute[3:0];
        end else begin
          inc_d       = 1'b1;
          frame_err_d = 1'b1;
          if (bad_cnt_q != CNT_MAX) bad_cnt_d = bad_cnt_q + CW'(1);
          if (bad_cnt_d == CNT_MAX) synced_d = 1'b0;
        end
      end else begin
        inc_d = 1'b1;
        if (sec_idx_q != 6'd63) sec_idx_d = sec_idx_q + 6'd1;
        if (sec_idx_d == 6'd63) frame_bad_d = 1'b1;
      end
    end

    // A coincident strobe sees the index the tick has just produced.
    if (bit_strobe_i) begin
      if (bit_err_i || got_bit_d) frame_bad_d = 1'b1;
      got_bit_d = 1'b1;
      seen_pos  = 4'(sec_idx_d - 6'd39);
      if (sec_idx_d >= 6'd39 && sec_idx_d <= 6'd51) begin
        cap_d            = {cap_d[11:0], bit_a_i};
        seen_d[seen_pos] = 1'b1;
      end else if (sec_idx_d == 6'd54) begin
        p54_d      = bit_b_i;
        seen_d[13] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sec_idx_q   <= '0;
      frame_bad_q <= 1'b1;
      got_bit_q   <= 1'b0;
      cap_q       <= '0;
      p54_q       <= 1'b0;
      seen_q      <= '0;
      bad_cnt_q   <= '0;
      inc_q       <= 1'b0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      synced_q    <= 1'b0;
      hour_h_q    <= '0;
      hour_l_q    <= '0;
      minute_h_q  <= '0;
      minute_l_q  <= '0;
    end else begin
      sec_idx_q   <= sec_idx_d;
      frame_bad_q <= frame_bad_d;
      got_bit_q   <= got_bit_d;
      cap_q       <= cap_d;
      p54_q       <= p54_d;
      seen_q      <= seen_d;
      bad_cnt_q   <= bad_cnt_d;
      inc_q       <= inc_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      synced_q    <= synced_d;
      hour_h_q    <= hour_h_d;
      hour_l_q    <= hour_l_d;
      minute_h_q  <= minute_h_d;
      minute_l_q  <= minute_l_d;
    end
  end

  assign inc_o       = inc_q;
  assign load_o      = load_q;
  assign frame_err_o = frame_err_q;
  assign synced_o    = synced_q;
  assign hour_h_o    = hour_h_q;
  assign hour_l_o    = hour_l_q;
  assign minute_h_o  = minute_h_q;
  assign minute_l_o  = minute_l_q;
  assign second_h_o  = '0;
  assign second_l_o  = '0;

endmodule
